// File: rtl/sequence_controller.sv
// Round controller for the memory-sequence game: grows a random colour sequence,
// plays it on the LEDs, checks the player's keys and reports the final score.
module sequence_controller #(
    parameter int MAX_LEN     = 15,
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       key_valid,
    input  logic [1:0] key_color,
    output logic [3:0] led,
    output logic [3:0] sequence_counter,
    output logic       load_current,
    output logic       load_best,
    output logic       awaiting_input,
    output logic       game_over
);

    localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_KEY,
        S_ROUND_DONE,
        S_END,
        S_GAME_OVER
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [4:0]    len_q, len_d;
    logic [3:0]    play_idx_q, play_idx_d;
    logic [3:0]    in_idx_q, in_idx_d;
    logic [3:0]    score_q, score_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    mem_q [16];
    logic          mem_we;

    logic [4:0]    len_m1;
    logic          play_last;
    logic          in_last;
    logic          key_match;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    // x^8+x^6+x^5+x^4+1 is maximal length, so the seed can never decay to zero.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign len_m1    = len_q - 5'd1;
    assign play_last = ({1'b0, play_idx_q} == len_m1);
    assign in_last   = ({1'b0, in_idx_q} == len_m1);
    assign key_match = (key_color == mem_q[in_idx_q]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 8'hA5;
            len_q      <= 5'd0;
            play_idx_q <= 4'd0;
            in_idx_q   <= 4'd0;
            score_q    <= 4'd0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            len_q      <= len_d;
            play_idx_q <= play_idx_d;
            in_idx_q   <= in_idx_d;
            score_q    <= score_d;
            timer_q    <= timer_d;
        end
    end

    // The colour store is pure data; len gates every read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[len_q[3:0]] <= lfsr_q[1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        play_idx_d = play_idx_q;
        in_idx_d   = in_idx_q;
        score_d    = score_q;
        timer_d    = timer_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    score_d = 4'd0;
                    len_d   = 5'd0;
                    state_d = S_APPEND;
                end
            end
            S_APPEND: begin
                mem_we     = 1'b1;
                len_d      = len_q + 5'd1;
                play_idx_d = 4'd0;
                timer_d    = SHOW_LOAD;
                state_d    = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LOAD;
                    state_d = S_SHOW_OFF;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SHOW_OFF: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (play_last) begin
                    in_idx_d = 4'd0;
                    state_d  = S_WAIT_KEY;
                end else begin
                    play_idx_d = play_idx_q + 4'd1;
                    timer_d    = SHOW_LOAD;
                    state_d    = S_SHOW_ON;
                end
            end
            S_WAIT_KEY: begin
                if (key_valid) begin
                    if (!key_match) begin
                        state_d = S_END;
                    end else if (in_last) begin
                        state_d = S_ROUND_DONE;
                    end else begin
                        in_idx_d = in_idx_q + 4'd1;
                    end
                end
            end
            S_ROUND_DONE: begin
                score_d = len_q[3:0];
                state_d = (len_q == LEN_MAX) ? S_END : S_APPEND;
            end
            S_END: begin
                state_d = S_GAME_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        led = 4'd0;
        if (state_q == S_SHOW_ON) begin
            led = onehot(mem_q[play_idx_q]);
        end
    end

    assign sequence_counter = score_q;
    assign load_current     = (state_q == S_END);
    assign load_best        = (state_q == S_END);
    assign awaiting_input   = (state_q == S_WAIT_KEY);
    assign game_over        = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_sequence_controller.sv
// Scoreboard bench for sequence_controller: stimulus queues expected LED steps,
// score changes and load pulses; a negedge monitor pops and compares them.
module tb_sequence_controller;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int MAXL = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_color = 2'd0;
    logic [3:0] led;
    logic [3:0] sequence_counter;
    logic       load_current;
    logic       load_best;
    logic       awaiting_input;
    logic       game_over;

    always #5 clk = ~clk;

    sequence_controller #(
        .MAX_LEN    (MAXL),
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .key_valid       (key_valid),
        .key_color       (key_color),
        .led             (led),
        .sequence_counter(sequence_counter),
        .load_current    (load_current),
        .load_best       (load_best),
        .awaiting_input  (awaiting_input),
        .game_over       (game_over)
    );

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_led_q[$];
    logic [3:0] exp_cnt_q[$];
    logic [3:0] exp_load_q[$];
    logic [1:0] seq[16];
    logic [3:0] exp_score = 4'd0;
    logic [7:0] m;

    // Reference LFSR built from the polynomial x^8+x^6+x^5+x^4+1, seed A5.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= 8'hA5;
        else         m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({led, sequence_counter, load_current, load_best, awaiting_input, game_over});
    endfunction

    // Monitor state
    logic [3:0] prev_led = 4'd0;
    logic [3:0] lit_val = 4'd0;
    logic [3:0] prev_sc = 4'd0;
    int         lit_cnt = 0;
    int         gap_cnt = 0;
    bit         gap_active = 1'b0;
    bit         stable = 1'b1;
    bit         load_pending = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_led = 4'd0; prev_sc = 4'd0; lit_cnt = 0;
                gap_active = 1'b0; load_pending = 1'b0;
                continue;
            end
            if (load_pending) begin
                check("post_load_pulse_low", 32'(load_current), 32'd0);
                check("post_load_game_over", 32'(game_over), 32'd1);
                check("post_load_led_dark", 32'(led), 32'd0);
                load_pending = 1'b0;
            end
            if (led != 4'd0 && prev_led == 4'd0) begin
                if (gap_active) begin
                    check("gap_len", 32'(gap_cnt), 32'(GAP));
                    gap_active = 1'b0;
                end
                if (exp_led_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL led_unexpected: got %b required dark", led);
                end else begin
                    check("led_colour", 32'(led), 32'(exp_led_q.pop_front()));
                end
                lit_val = led; lit_cnt = 1; stable = 1'b1;
            end else if (led != 4'd0) begin
                if (led !== lit_val) stable = 1'b0;
                lit_cnt++;
            end else if (prev_led != 4'd0) begin
                check("lit_len", 32'(lit_cnt), 32'(SHOW));
                check("led_stable", 32'(stable), 32'd1);
                gap_active = 1'b1; gap_cnt = 1;
            end else if (gap_active) begin
                if (awaiting_input) begin
                    check("gap_len", 32'(gap_cnt), 32'(GAP));
                    gap_active = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            prev_led = led;
            if (sequence_counter !== prev_sc) begin
                if (exp_cnt_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL score_unexpected: got %0d required %0d", sequence_counter, prev_sc);
                end else begin
                    check("score_update", 32'(sequence_counter), 32'(exp_cnt_q.pop_front()));
                end
                prev_sc = sequence_counter;
            end
            if (load_current) begin
                check("load_best_with_current", 32'(load_best), 32'd1);
                if (exp_load_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL load_unexpected: got pulse score=%0d required none", sequence_counter);
                end else begin
                    check("load_score", 32'(sequence_counter), 32'(exp_load_q.pop_front()));
                end
                load_pending = 1'b1;
            end
        end
    end

    task automatic wait_await(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (awaiting_input) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL await_timeout: awaiting_input=0 after 200 cycles, required 1");
        end
    endtask

    task automatic wait_gameover();
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (game_over) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL game_over_timeout: game_over=0 after 50 cycles, required 1");
        end
    endtask

    // Returns at the negedge of the APPEND cycle, after recording colour 0.
    task automatic do_start();
        if (exp_score != 4'd0) exp_cnt_q.push_back(4'd0);
        exp_score = 4'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seq[0] = m[1:0];
        exp_led_q.push_back(onehot(seq[0]));
    endtask

    task automatic play_round(input int r, input int fail_at, input bit with_start);
        for (int i = 0; i < r; i++) begin
            logic [1:0] col;
            bit         ok;
            bit         last_ok;
            wait_await(ok);
            if (!ok) return;
            col = (i == fail_at) ? (seq[i] ^ 2'd1) : seq[i];
            last_ok = (i == r - 1) && (i != fail_at);
            if (i == fail_at) exp_load_q.push_back(exp_score);
            if (last_ok) begin
                exp_score = 4'(r);
                exp_cnt_q.push_back(exp_score);
                if (r == MAXL) exp_load_q.push_back(exp_score);
            end
            key_valid = 1'b1;
            key_color = col;
            if (with_start && i == 0) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            key_valid = 1'b0;
            start = 1'b0;
            if (i == fail_at) return;
            if (last_ok) begin
                if (r < MAXL) begin
                    @(negedge clk);
                    seq[r] = m[1:0];
                    for (int j = 0; j <= r; j++) exp_led_q.push_back(onehot(seq[j]));
                end
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_outputs", outs(), 32'd0);
        check("reset_lfsr", 32'(dut.lfsr_q), 32'hA5);
        @(negedge clk);
        resetn = 1'b1;

        // Keys with no start leave the controller idle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            key_valid = 1'b1;
            key_color = 2'(i);
            @(negedge clk);
            key_valid = 1'b0;
            check("idle_ignores_key", outs(), 32'd0);
        end

        // Game 1: round 1 correct, round 2 fails on the second key.
        do_start();
        play_round(1, -1, 1'b0);
        play_round(2, 1, 1'b0);
        wait_gameover();

        // Game 2: key during SHOW_ON ignored, start during WAIT_KEY ignored, win.
        do_start();
        @(negedge clk);
        key_valid = 1'b1;
        key_color = seq[0];
        @(negedge clk);
        key_valid = 1'b0;
        check("show_key_ignored_await", 32'(awaiting_input), 32'd0);
        check("show_key_ignored_score", 32'(sequence_counter), 32'd0);
        play_round(1, -1, 1'b0);
        play_round(2, -1, 1'b1);
        play_round(3, -1, 1'b0);
        wait_gameover();

        // Game 3: asynchronous reset while the first step is lit.
        do_start();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 32'd0);
        check("async_reset_lfsr", 32'(dut.lfsr_q), 32'hA5);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        exp_score = 4'd0;
        repeat (10) @(negedge clk);
        check("post_reset_idle", outs(), 32'd0);

        check("led_queue_drained", 32'(exp_led_q.size()), 32'd0);
        check("score_queue_drained", 32'(exp_cnt_q.size()), 32'd0);
        check("load_queue_drained", 32'(exp_load_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
